// File: rtl/sda_kernel_ctrl_result.sv
// Result RAM fed by a kernel write stream through a 2-entry skid buffer, with host register access.
// Define SDA_KERNEL_RESULT_COUNT_EN to build the in-window commit counter at CountAddr.
module sda_kernel_ctrl_result #(
    parameter int unsigned RegAddrWidth   = 12,
    parameter int unsigned ResultAddrBase = 64,
    parameter int unsigned ResultAddrTop  = 4095,
    parameter int unsigned CountAddr      = 60
) (
    input  logic                    clk,
    input  logic                    srst,
    input  logic                    regReq,
    output logic                    regAck,
    input  logic                    regWriteEn,
    input  logic [RegAddrWidth-1:0] regAddr,
    input  logic [31:0]             regWData,
    input  logic [3:0]              regWStrb,
    output logic [31:0]             regRData,
    input  logic                    resultValid,
    input  logic [31:0]             resultAddr,
    input  logic [31:0]             resultData,
    output logic                    resultStop
);
    localparam int unsigned Depth = (ResultAddrTop - ResultAddrBase + 1) / 4;
    localparam int unsigned IdxW  = $clog2(Depth);
    localparam int unsigned WordW = RegAddrWidth - 2;
    localparam logic [WordW-1:0] BaseWord = WordW'(ResultAddrBase / 4);

    function automatic logic in_window(input logic [31:0] a);
        return (a >= ResultAddrBase) && (a <= ResultAddrTop);
    endfunction

    function automatic logic [IdxW-1:0] word_index(input logic [WordW-1:0] w);
        logic [WordW-1:0] d;
        d = w - BaseWord;
        return d[IdxW-1:0];
    endfunction

    typedef enum logic [2:0] {H_IDLE, H_DECODE, H_ACCESS, H_READ1, H_READ2} host_state_t;

    host_state_t      h_state;
    logic             req_q;
    logic             h_we;
    logic [WordW-1:0] h_word;
    logic [31:0]      h_wdata;
    logic [3:0]       h_strb;
    logic             h_inwin;
    logic             h_iscount;
    logic [IdxW-1:0]  h_idx;
    logic [31:0]      cnt_snap;
    logic [31:0]      rd_hold;
    logic [31:0]      ram_q;
    logic [31:0]      count;
    logic             host_wr;

    logic [31:0]      ram [Depth];

    logic [29:0]      fifo_word [2];
    logic [31:0]      fifo_data [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       fifo_cnt;
    logic [29:0]      head_word;
    logic             push;
    logic             pop;
    logic             dec_adv;
    logic             dec_valid;
    logic             dec_inwin;
    logic [IdxW-1:0]  dec_idx;
    logic [31:0]      dec_data;
    logic             kern_wr;
    logic             unused_addr_lsbs;

`ifdef SDA_KERNEL_RESULT_COUNT_EN
    localparam logic CountEn = 1'b1;
`else
    localparam logic CountEn = 1'b0;
`endif

    assign unused_addr_lsbs = ^{regAddr[1:0], resultAddr[1:0]};

    assign host_wr    = (h_state == H_ACCESS) && h_we && h_inwin && !srst;
    assign resultStop = (fifo_cnt == 2'd2);
    assign push       = resultValid && !resultStop;
    // A host write owns the RAM port; an in-window decode entry waits one cycle.
    assign dec_adv    = !(dec_valid && dec_inwin && host_wr);
    assign pop        = dec_adv && (fifo_cnt != 2'd0);
    assign kern_wr    = dec_valid && dec_inwin && !host_wr && !srst;
    assign head_word  = fifo_word[rd_ptr];

    always_ff @(posedge clk) begin
        req_q    <= regReq;
        regAck   <= 1'b0;
        regRData <= '0;
        if (srst) begin
            h_state <= H_IDLE;
        end else begin
            case (h_state)
                H_IDLE: begin
                    if (regReq && !req_q) begin
                        h_we    <= regWriteEn;
                        h_word  <= regAddr[RegAddrWidth-1:2];
                        h_wdata <= regWData;
                        h_strb  <= regWStrb;
                        h_state <= H_DECODE;
                    end
                end
                H_DECODE: begin
                    h_inwin   <= in_window(32'({h_word, 2'b00}));
                    h_iscount <= CountEn && (32'({h_word, 2'b00}) == CountAddr);
                    h_idx     <= word_index(h_word);
                    h_state   <= H_ACCESS;
                end
                H_ACCESS: begin
                    if (h_we) begin
                        regAck  <= h_inwin || h_iscount;
                        h_state <= H_IDLE;
                    end else if (h_inwin || h_iscount) begin
                        cnt_snap <= count;
                        h_state  <= H_READ1;
                    end else begin
                        h_state <= H_IDLE;
                    end
                end
                H_READ1: begin
                    rd_hold <= h_iscount ? cnt_snap : ram_q;
                    h_state <= H_READ2;
                end
                H_READ2: begin
                    regAck   <= 1'b1;
                    regRData <= rd_hold;
                    h_state  <= H_IDLE;
                end
                default: h_state <= H_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            fifo_cnt  <= '0;
            dec_valid <= 1'b0;
        end else begin
            if (push) begin
                fifo_word[wr_ptr] <= resultAddr[31:2];
                fifo_data[wr_ptr] <= resultData;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
            if (dec_adv) begin
                dec_valid <= (fifo_cnt != 2'd0);
                dec_inwin <= in_window({head_word, 2'b00});
                dec_idx   <= word_index(head_word[WordW-1:0]);
                dec_data  <= fifo_data[rd_ptr];
            end
        end
    end

    // RAM is never reset; a single write port shared by host (priority) and kernel.
    always_ff @(posedge clk) begin
        ram_q <= ram[h_idx];
        if (host_wr) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (h_strb[b]) begin
                    ram[h_idx][8*b +: 8] <= h_wdata[8*b +: 8];
                end
            end
        end else if (kern_wr) begin
            ram[dec_idx] <= dec_data;
        end
    end

`ifdef SDA_KERNEL_RESULT_COUNT_EN
    logic cnt_clear;
    assign cnt_clear = (h_state == H_ACCESS) && h_we && h_iscount;

    always_ff @(posedge clk) begin
        if (srst) begin
            count <= '0;
        end else if (cnt_clear) begin
            count <= '0;
        end else if (kern_wr) begin
            count <= count + 32'd1;
        end
    end
`else
    assign count = '0;
`endif

endmodule

// File: tb/tb_sda_kernel_ctrl_result.sv
// Bench for sda_kernel_ctrl_result: vector table, directed corner sequences and a randomized
// phase against a word-addressed memory model. Honours SDA_KERNEL_RESULT_COUNT_EN if defined.
module tb_sda_kernel_ctrl_result;
    logic        clk = 1'b0;
    logic        srst;
    logic        regReq;
    logic        regAck;
    logic        regWriteEn;
    logic [11:0] regAddr;
    logic [31:0] regWData;
    logic [3:0]  regWStrb;
    logic [31:0] regRData;
    logic        resultValid;
    logic [31:0] resultAddr;
    logic [31:0] resultData;
    logic        resultStop;

    always #5 clk = ~clk;

    sda_kernel_ctrl_result #(
        .RegAddrWidth  (12),
        .ResultAddrBase(64),
        .ResultAddrTop (4095),
        .CountAddr     (60)
    ) dut (
        .clk        (clk),
        .srst       (srst),
        .regReq     (regReq),
        .regAck     (regAck),
        .regWriteEn (regWriteEn),
        .regAddr    (regAddr),
        .regWData   (regWData),
        .regWStrb   (regWStrb),
        .regRData   (regRData),
        .resultValid(resultValid),
        .resultAddr (resultAddr),
        .resultData (resultData),
        .resultStop (resultStop)
    );

    int n_vec = 0;
    int n_bad = 0;

    logic [31:0] model [int];
    logic [31:0] k_addr [$];
    logic [31:0] k_data [$];

    typedef struct {
        logic        we;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic        exp_ack;
        int          exp_lat;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t tbl [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic in_win(input logic [31:0] a);
        return (a >= 32'd64) && (a <= 32'd4095);
    endfunction

    function automatic void m_kernel(input logic [31:0] a, input logic [31:0] d);
        if (in_win(a)) model[int'(a >> 2)] = d;
    endfunction

    function automatic void m_host(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
        int k;
        logic [31:0] w;
        k = int'(a[11:2]);
        w = model.exists(k) ? model[k] : 32'h0;
        for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
        model[k] = w;
    endfunction

    // Starts and ends on a falling edge; lat = number of rising edges after the request edge.
    task automatic host_access(input logic we, input logic [11:0] addr, input logic [31:0] wdata,
                               input logic [3:0] strb, output logic acked, output int lat,
                               output logic [31:0] rdata, output logic leak);
        regReq = 1'b1; regWriteEn = we; regAddr = addr; regWData = wdata; regWStrb = strb;
        acked = 1'b0; lat = -1; rdata = '0; leak = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk); @(negedge clk);
            if (regAck) begin
                acked = 1'b1; lat = n; rdata = regRData;
                break;
            end
            if (regRData != 32'h0) leak = 1'b1;
        end
        regReq = 1'b0;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic host_write_chk(input logic [11:0] addr, input logic [31:0] d, input logic [3:0] s,
                                  input string name);
        logic a, lk; int lat; logic [31:0] rd;
        host_access(1'b1, addr, d, s, a, lat, rd, lk);
        check({name, " ack"}, 32'(a), 32'd1);
        check({name, " lat"}, lat, 32'd2);
        m_host(addr, d, s);
    endtask

    task automatic host_read_chk(input logic [11:0] addr, input string name);
        logic a, lk; int lat; logic [31:0] rd;
        host_access(1'b0, addr, 32'h0, 4'h0, a, lat, rd, lk);
        check({name, " ack"}, 32'(a), 32'd1);
        check({name, " lat"}, lat, 32'd4);
        check({name, " data"}, rd, model[int'(addr[11:2])]);
    endtask

    task automatic host_noack_chk(input logic we, input logic [11:0] addr, input string name);
        logic a, lk; int lat; logic [31:0] rd;
        host_access(we, addr, 32'hFFFF_FFFF, 4'hF, a, lat, rd, lk);
        check({name, " no ack"}, 32'(a), 32'd0);
        check({name, " rdata zero"}, 32'(lk), 32'd0);
    endtask

    task automatic kernel_stream(input string name, output int stops);
        int i, t;
        i = 0; t = 0; stops = 0;
        while (i < k_addr.size() && t < 200) begin
            resultValid = 1'b1; resultAddr = k_addr[i]; resultData = k_data[i];
            if (resultStop) stops++;
            else i++;
            @(posedge clk); @(negedge clk);
            t++;
        end
        resultValid = 1'b0;
        check({name, " all accepted"}, i, k_addr.size());
        foreach (k_addr[j]) m_kernel(k_addr[j], k_data[j]);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); @(negedge clk); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int stops;
        logic a, lk; int lat; logic [31:0] rd;

        srst = 1'b1; regReq = 1'b0; regWriteEn = 1'b0; regAddr = '0; regWData = '0; regWStrb = '0;
        resultValid = 1'b0; resultAddr = '0; resultData = '0;
        repeat (3) @(negedge clk);
        check("reset regAck", 32'(regAck), 32'd0);
        check("reset regRData", regRData, 32'd0);
        check("reset resultStop", 32'(resultStop), 32'd0);
        srst = 1'b0;
        idle(2);

        // host-only vector table
        tbl.push_back('{1'b1, 12'h040, 32'hA5A5_A5A5, 4'hF, 1'b1, 2, 32'h0});
        tbl.push_back('{1'b0, 12'h040, 32'h0,         4'h0, 1'b1, 4, 32'hA5A5_A5A5});
        tbl.push_back('{1'b1, 12'h040, 32'h1122_3344, 4'h3, 1'b1, 2, 32'h0});
        tbl.push_back('{1'b0, 12'h040, 32'h0,         4'h0, 1'b1, 4, 32'hA5A5_3344});
        tbl.push_back('{1'b0, 12'h042, 32'h0,         4'h0, 1'b1, 4, 32'hA5A5_3344});
        tbl.push_back('{1'b1, 12'hFFC, 32'hCAFE_F00D, 4'hF, 1'b1, 2, 32'h0});
        tbl.push_back('{1'b1, 12'hFFE, 32'h7700_0000, 4'h8, 1'b1, 2, 32'h0});
        tbl.push_back('{1'b0, 12'hFFC, 32'h0,         4'h0, 1'b1, 4, 32'h77FE_F00D});
        tbl.push_back('{1'b0, 12'h020, 32'h0,         4'h0, 1'b0, 0, 32'h0});
        tbl.push_back('{1'b1, 12'h000, 32'h1234_5678, 4'hF, 1'b0, 0, 32'h0});
        tbl.push_back('{1'b0, 12'h038, 32'h0,         4'h0, 1'b0, 0, 32'h0});
        foreach (tbl[i]) begin
            host_access(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].strb, a, lat, rd, lk);
            check($sformatf("tbl%0d ack", i), 32'(a), 32'(tbl[i].exp_ack));
            if (tbl[i].exp_ack) begin
                check($sformatf("tbl%0d lat", i), lat, tbl[i].exp_lat);
                if (!tbl[i].we) check($sformatf("tbl%0d rdata", i), rd, tbl[i].exp_rdata);
            end else begin
                check($sformatf("tbl%0d rdata zero", i), 32'(lk), 32'd0);
            end
        end
        model[int'(12'h040 >> 2)] = 32'hA5A5_3344;
        model[int'(12'hFFC >> 2)] = 32'h77FE_F00D;

        // kernel write then host read
        k_addr = '{32'h40}; k_data = '{32'hDEAD_BEEF};
        kernel_stream("k40", stops);
        idle(5);
        host_read_chk(12'h040, "rd40 after kernel");

        // strobed host write, then kernel overwrite
        host_write_chk(12'h044, 32'h0, 4'hF, "wr44 zero");
        host_write_chk(12'h044, 32'hFFFF_FFFF, 4'h5, "wr44 strobe");
        host_read_chk(12'h044, "rd44 strobe");
        check("rd44 strobe model", model[int'(12'h044 >> 2)], 32'h00FF_00FF);
        k_addr = '{32'h44}; k_data = '{32'h1234_5678};
        kernel_stream("k44", stops);
        idle(3);
        host_read_chk(12'h044, "rd44 kernel");

        // host and kernel commit to the same word on the same edge
        k_addr = '{32'h48}; k_data = '{32'h0BAD_CAFE};
        fork
            host_write_chk(12'h048, 32'hAAAA_5555, 4'hF, "wr48 collide");
            kernel_stream("k48 collide", stops);
        join
        model[int'(12'h048 >> 2)] = 32'h0BAD_CAFE;
        idle(3);
        host_read_chk(12'h048, "rd48 kernel wins");

        // streaming throughput without and with a host write
        k_addr.delete(); k_data.delete();
        for (int i = 0; i < 8; i++) begin
            k_addr.push_back(32'h300 + 32'(4 * i)); k_data.push_back($urandom);
        end
        kernel_stream("stream free", stops);
        check("stream free stop cycles", stops, 32'd0);
        k_addr.delete(); k_data.delete();
        for (int i = 0; i < 8; i++) begin
            k_addr.push_back(32'h200 + 32'(4 * i)); k_data.push_back($urandom);
        end
        fork
            host_write_chk(12'h100, 32'h5555_AAAA, 4'hF, "wr100 during stream");
            kernel_stream("stream collide", stops);
        join
        check("stream collide stop <= 1", 32'(stops <= 1), 32'd1);
        idle(3);
        for (int i = 0; i < 8; i++) host_read_chk(12'(32'h200 + 4 * i), $sformatf("rd stream%0d", i));
        host_read_chk(12'h100, "rd100");

        // window edges: top word accepted, aliasing out-of-window addresses discarded
        k_addr = '{32'hFFC, 32'h1000, 32'h1040, 32'h8000_0044};
        k_data = '{32'h1357_9BDF, 32'h2468_ACE0, 32'h5A5A_5A5A, 32'h6B6B_6B6B};
        kernel_stream("k edges", stops);
        idle(3);
        host_read_chk(12'hFFC, "rd top word");
        host_read_chk(12'h040, "rd40 no alias");
        host_read_chk(12'h044, "rd44 no alias");

        host_noack_chk(1'b0, 12'h020, "rd20");
`ifndef SDA_KERNEL_RESULT_COUNT_EN
        host_noack_chk(1'b0, 12'h03C, "rd count disabled");
        host_noack_chk(1'b1, 12'h03C, "wr count disabled");
`endif

        // reset in the middle of a host read drops the access
        regReq = 1'b1; regWriteEn = 1'b0; regAddr = 12'h040;
        idle(2);
        srst = 1'b1;
        idle(1);
        srst = 1'b0;
        a = 1'b0;
        for (int n = 0; n < 6; n++) begin
            if (regAck) a = 1'b1;
            idle(1);
        end
        check("reset drops host read", 32'(a), 32'd0);
        regReq = 1'b0;
        idle(1);

        // reset in the middle of a kernel stream; transfer during srst discarded
        host_write_chk(12'h080, 32'h0, 4'hF, "wr80 zero");
        resultValid = 1'b1; resultAddr = 32'h84; resultData = 32'h1;
        idle(1);
        resultAddr = 32'h88; resultData = 32'h2;
        idle(1);
        srst = 1'b1; resultAddr = 32'h80; resultData = 32'h0000_0BAD;
        idle(1);
        srst = 1'b0; resultValid = 1'b0;
        check("reset mid-stream resultStop", 32'(resultStop), 32'd0);
        check("reset mid-stream regAck", 32'(regAck), 32'd0);
        model.delete(int'(32'h84 >> 2)); model.delete(int'(32'h88 >> 2));
        idle(4);
        host_read_chk(12'h080, "rd80 discard during srst");

`ifdef SDA_KERNEL_RESULT_COUNT_EN
        host_read_chk(12'h03C, "count after reset");
        k_addr = '{32'h40, 32'h44, 32'h1040, 32'h48};
        k_data = '{32'h1, 32'h2, 32'h3, 32'h4};
        kernel_stream("k count", stops);
        idle(4);
        model[15] = 32'd3;
        host_read_chk(12'h03C, "count three");
        host_write_chk(12'h03C, 32'hFFFF_FFFF, 4'hF, "count clear");
        model[15] = 32'd0;
        host_read_chk(12'h03C, "count cleared");
        resultValid = 1'b1; resultAddr = 32'h4C; resultData = 32'h9;
        idle(2);
        srst = 1'b1;
        idle(1);
        srst = 1'b0; resultValid = 1'b0;
        check("count reset resultStop", 32'(resultStop), 32'd0);
        model.delete(int'(32'h4C >> 2));
        idle(4);
        host_read_chk(12'h03C, "count after mid-stream reset");
`endif

        // randomized phase against the memory model
        for (int i = 0; i < 16; i++) host_write_chk(12'(32'h40 + 4 * i), $urandom, 4'hF, "rnd init");
        for (int r = 0; r < 40; r++) begin
            case ($urandom_range(0, 2))
                0: begin
                    k_addr.delete(); k_data.delete();
                    repeat ($urandom_range(1, 6)) begin
                        if ($urandom_range(0, 4) == 0)
                            k_addr.push_back(($urandom_range(0, 1) == 0) ? 32'h1040 + 32'($urandom_range(0, 15) * 4)
                                                                          : 32'h10);
                        else
                            k_addr.push_back(32'h40 + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3)));
                        k_data.push_back($urandom);
                    end
                    kernel_stream($sformatf("rnd%0d stream", r), stops);
                    idle(3);
                end
                1: host_write_chk(12'(32'h40 + $urandom_range(0, 15) * 4), $urandom,
                                  4'($urandom_range(0, 15)), $sformatf("rnd%0d wr", r));
                default: host_read_chk(12'(32'h40 + $urandom_range(0, 15) * 4 + $urandom_range(0, 3)),
                                       $sformatf("rnd%0d rd", r));
            endcase
        end
        for (int i = 0; i < 16; i++) host_read_chk(12'(32'h40 + 4 * i), $sformatf("rnd final%0d", i));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
